l2_flush_sequencer: RTL and testbench

- Sequences a full L2 flush (writeback and invalidate of every line).
- Accepts a flush request, waits for all MSHRs to drain, then walks every set/way and issues one flush step per granted decode slot. Forwards keep priority over flush steps.
- Waits for the trailing writebacks to drain, then signals completion.
- Sits beside the L2 input decoder and supplies its ongoing-flush, flush-step and flush-done controls.

---
 rtl/l2_flush_sequencer.sv | 150 +++++++++++++++
 tb/tb_l2_flush_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_flush_sequencer.sv
// Full-L2 flush sequencer: drains MSHRs, walks every set/way one step at a time,
// drains trailing writebacks, then pulses flush_done. Optional stats: L2_FLUSH_STATS_EN.
module l2_flush_sequencer #(
  parameter int unsigned L2_SETS = 256,
  parameter int unsigned L2_WAYS = 8,
  parameter int unsigned N_MSHR  = 4,
  localparam int unsigned SET_W  = $clog2(L2_SETS),
  localparam int unsigned WAY_W  = $clog2(L2_WAYS),
  localparam int unsigned CNT_W  = $clog2(N_MSHR + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_valid,
  output logic             flush_ready,
  input  logic             decode_en,
  input  logic             fwd_in_valid,
  input  logic [CNT_W-1:0] mshr_cnt,
  output logic             step_issue,
  output logic [SET_W-1:0] step_set,
  output logic [WAY_W-1:0] step_way,
  input  logic             step_done,
  output logic             ongoing_flush,
  output logic             flush_done
`ifdef L2_FLUSH_STATS_EN
  ,
  output logic [31:0]      flush_cycles,
  output logic [31:0]      flush_steps
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StDrain,
    StWalk,
    StWait,
    StFinish
  } state_e;

  localparam logic [CNT_W-1:0] MshrAll = CNT_W'(N_MSHR);
  localparam logic [SET_W-1:0] SetLast = SET_W'(L2_SETS - 1);
  localparam logic [WAY_W-1:0] WayLast = WAY_W'(L2_WAYS - 1);

  state_e           state_q, state_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [WAY_W-1:0] way_q, way_d;
  logic             done_q, done_d;

  logic mshr_all;
  logic accept;

  assign mshr_all      = (mshr_cnt == MshrAll);
  assign flush_ready   = (state_q == StIdle);
  assign accept        = flush_ready && flush_valid;
  // Forwards keep the decode slot; a step also needs at least one free MSHR.
  assign step_issue    = (state_q == StWalk) && decode_en && !fwd_in_valid &&
                         (mshr_cnt != '0);
  assign step_set      = set_q;
  assign step_way      = way_q;
  assign ongoing_flush = (state_q != StIdle);
  assign flush_done    = done_q;

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    way_d   = way_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StDrain;
          set_d   = '0;
          way_d   = '0;
        end
      end
      StDrain: begin
        if (mshr_all) state_d = StWalk;
      end
      StWalk: begin
        if (step_issue) state_d = StWait;
      end
      StWait: begin
        if (step_done) begin
          if (way_q == WayLast && set_q == SetLast) begin
            state_d = StFinish;
          end else if (way_q == WayLast) begin
            way_d   = '0;
            set_d   = set_q + SET_W'(1);
            state_d = StWalk;
          end else begin
            way_d   = way_q + WAY_W'(1);
            state_d = StWalk;
          end
        end
      end
      StFinish: begin
        if (mshr_all) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      set_q   <= '0;
      way_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      way_q   <= way_d;
      done_q  <= done_d;
    end
  end

`ifdef L2_FLUSH_STATS_EN
  logic [31:0] cycles_q, cycles_d;
  logic [31:0] steps_q, steps_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    cycles_d = cycles_q;
    steps_d  = steps_q;
    if (accept) begin
      cycles_d = '0;
      steps_d  = '0;
    end else begin
      if (ongoing_flush && !(&cycles_q)) cycles_d = cycles_q + 32'd1;
      if (step_issue && !(&steps_q))     steps_d  = steps_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycles_q <= '0;
      steps_q  <= '0;
    end else begin
      cycles_q <= cycles_d;
      steps_q  <= steps_d;
    end
  end

  assign flush_cycles = cycles_q;
  assign flush_steps  = steps_q;
`endif

endmodule

// File: tb/tb_l2_flush_sequencer.sv
// Directed self-checking bench for l2_flush_sequencer (4 sets, 2 ways, 4 MSHRs).
module tb_l2_flush_sequencer;

  localparam int unsigned Sets  = 4;
  localparam int unsigned Ways  = 2;
  localparam int unsigned Mshrs = 4;

  logic       clk;
  logic       rst;
  logic       flush_valid;
  logic       flush_ready;
  logic       decode_en;
  logic       fwd_in_valid;
  logic [2:0] mshr_cnt;
  logic       step_issue;
  logic [1:0] step_set;
  logic [0:0] step_way;
  logic       step_done;
  logic       ongoing_flush;
  logic       flush_done;
`ifdef L2_FLUSH_STATS_EN
  logic [31:0] flush_cycles;
  logic [31:0] flush_steps;
`endif

  int tests_run;
  int tests_failed;

  l2_flush_sequencer #(
    .L2_SETS(Sets),
    .L2_WAYS(Ways),
    .N_MSHR (Mshrs)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_valid  (flush_valid),
    .flush_ready  (flush_ready),
    .decode_en    (decode_en),
    .fwd_in_valid (fwd_in_valid),
    .mshr_cnt     (mshr_cnt),
    .step_issue   (step_issue),
    .step_set     (step_set),
    .step_way     (step_way),
    .step_done    (step_done),
    .ongoing_flush(ongoing_flush),
    .flush_done   (flush_done)
`ifdef L2_FLUSH_STATS_EN
    ,
    .flush_cycles (flush_cycles),
    .flush_steps  (flush_steps)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after posedge; outputs are sampled on negedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Issue and complete steps first..last (step k -> set k/2, way k%2).
  task automatic walk(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      sample();
      check($sformatf("issue%0d", k), {31'd0, step_issue}, 32'd1);
      check($sformatf("set%0d", k), {30'd0, step_set}, k / 2);
      check($sformatf("way%0d", k), {31'd0, step_way}, k % 2);
      step();
      step_done = 1'b1;
      sample();
      check($sformatf("wait_noissue%0d", k), {31'd0, step_issue}, 32'd0);
      check($sformatf("wait_rdy%0d", k), {31'd0, flush_ready}, 32'd0);
      step();
      step_done = 1'b0;
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    flush_valid  = 1'b0;
    decode_en    = 1'b1;
    fwd_in_valid = 1'b0;
    mshr_cnt     = 3'd4;
    step_done    = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    sample();
    check("rst_ongoing", {31'd0, ongoing_flush}, 32'd0);
    check("rst_ready", {31'd0, flush_ready}, 32'd1);
    check("rst_done", {31'd0, flush_done}, 32'd0);
    check("rst_set", {30'd0, step_set}, 32'd0);
    check("rst_way", {31'd0, step_way}, 32'd0);
    check("rst_issue", {31'd0, step_issue}, 32'd0);

    // Basic flush
    flush_valid = 1'b1;
    step();
    flush_valid = 1'b0;
    sample();
    check("drain_ongoing", {31'd0, ongoing_flush}, 32'd1);
    check("drain_ready", {31'd0, flush_ready}, 32'd0);
    check("drain_issue", {31'd0, step_issue}, 32'd0);
    step();
    walk(0, 7);
    sample();
    check("finish_ongoing", {31'd0, ongoing_flush}, 32'd1);
    check("finish_done", {31'd0, flush_done}, 32'd0);
    step();
    sample();
    check("done_pulse", {31'd0, flush_done}, 32'd1);
    check("done_ongoing", {31'd0, ongoing_flush}, 32'd0);
    check("done_ready", {31'd0, flush_ready}, 32'd1);
    check("done_set", {30'd0, step_set}, 32'd3);
    check("done_way", {31'd0, step_way}, 32'd1);
`ifdef L2_FLUSH_STATS_EN
    check("stat_cycles", flush_cycles, 32'd18);
    check("stat_steps", flush_steps, 32'd8);
`endif
    step();
    sample();
    check("done_once", {31'd0, flush_done}, 32'd0);
    check("idle_hold_set", {30'd0, step_set}, 32'd3);

    // Drain gating
    step_done = 1'b1;  // stray pulse in IDLE
    mshr_cnt  = 3'd2;
    flush_valid = 1'b1;
    step();
    flush_valid = 1'b0;
    step_done   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      check($sformatf("drain_gate%0d", i), {31'd0, step_issue}, 32'd0);
      check($sformatf("drain_set%0d", i), {30'd0, step_set}, 32'd0);
      step();
    end
    mshr_cnt = 3'd4;
    sample();
    check("drain_last", {31'd0, step_issue}, 32'd0);
    step();

    // Forward priority in WALK
    fwd_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check($sformatf("fwd_block%0d", i), {31'd0, step_issue}, 32'd0);
      check($sformatf("fwd_way%0d", i), {31'd0, step_way}, 32'd0);
      step();
    end
    fwd_in_valid = 1'b0;
    // Stray step_done and no free MSHR while in WALK
    decode_en = 1'b0;
    step_done = 1'b1;
    sample();
    check("walk_nodec", {31'd0, step_issue}, 32'd0);
    step();
    decode_en = 1'b1;
    step_done = 1'b0;
    mshr_cnt  = 3'd0;
    sample();
    check("walk_nomshr", {31'd0, step_issue}, 32'd0);
    step();
    mshr_cnt    = 3'd4;
    flush_valid = 1'b1;  // held through the walk
    walk(0, 6);
    sample();
    check("last_issue", {31'd0, step_issue}, 32'd1);
    check("held_ready", {31'd0, flush_ready}, 32'd0);
    step();
    step_done = 1'b1;
    mshr_cnt  = 3'd3;
    step();
    step_done = 1'b0;

    // Finish drain
    for (int i = 0; i < 6; i++) begin
      sample();
      check($sformatf("fin_nodone%0d", i), {31'd0, flush_done}, 32'd0);
      check($sformatf("fin_ongoing%0d", i), {31'd0, ongoing_flush}, 32'd1);
      step();
    end
    mshr_cnt = 3'd4;
    sample();
    check("fin_seen", {31'd0, flush_done}, 32'd0);
    step();
    sample();
    check("fin_done", {31'd0, flush_done}, 32'd1);
    check("fin_ready", {31'd0, flush_ready}, 32'd1);
    step();
    flush_valid = 1'b0;
    sample();
    check("reaccept_ongoing", {31'd0, ongoing_flush}, 32'd1);
    check("reaccept_set", {30'd0, step_set}, 32'd0);
    check("reaccept_done", {31'd0, flush_done}, 32'd0);
    step();

    // Reset mid-flush at step (2,1) in WAIT
    walk(0, 4);
    sample();
    check("pre_rst_set", {30'd0, step_set}, 32'd2);
    check("pre_rst_way", {31'd0, step_way}, 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sample();
    check("mid_rst_ongoing", {31'd0, ongoing_flush}, 32'd0);
    check("mid_rst_ready", {31'd0, flush_ready}, 32'd1);
    check("mid_rst_set", {30'd0, step_set}, 32'd0);
    check("mid_rst_way", {31'd0, step_way}, 32'd0);
    step_done = 1'b1;
    step();
    step_done = 1'b0;
    sample();
    check("stray_ongoing", {31'd0, ongoing_flush}, 32'd0);
    check("stray_way", {31'd0, step_way}, 32'd0);
    check("stray_issue", {31'd0, step_issue}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
